// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : shared opcode/funct/ALU/state encodings for the MIPS controller
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder : maps aluop/funct to ALU control, flags unknown R-type funct
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  always_comb begin
    alucontrol = ALU_ADD;
    bad_funct  = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   bad_funct  = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller : Moore FSM sequencing the multicycle datapath
// Revision                   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_controller
  import mips_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter bit ENABLE_BNE  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     cur_state;
  state_t     nxt_state;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       bne;
  logic       bad_funct;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = FETCH;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    iord      = 1'b0;
    pcsrc     = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    aluop     = ALUOP_ADD;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    bne       = 1'b0;
    illegal   = 1'b0;
    case (cur_state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = 1'b1;
        pcwrite   = 1'b1;
        nxt_state = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        // Disabled optional opcodes fall through to the illegal path
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE:     nxt_state = RTYPEEX;
          OP_BEQ:       nxt_state = BEQEX;
          OP_BNE:       if (ENABLE_BNE)  nxt_state = BNEEX;  else illegal = 1'b1;
          OP_ADDI:      if (ENABLE_ADDI) nxt_state = ADDIEX; else illegal = 1'b1;
          OP_J:         if (ENABLE_JUMP) nxt_state = JEX;    else illegal = 1'b1;
          default:      illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      nxt_state = MEMRD;
        else if (op == OP_SW) nxt_state = MEMWR;
      end
      MEMRD: begin
        iord      = 1'b1;
        nxt_state = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_FUNCT;
        illegal   = bad_funct;
        nxt_state = RTYPEWB;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        bne     = (cur_state == BNEEX);
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
  end

  assign pcen  = pcwrite | (branch & (zero ^ bne));
  assign state = cur_state;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .bad_funct  (bad_funct)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_controller : directed self-checking bench for the FSM
// Revision                      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite, regwrite, pcen, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       nj_memtoreg, nj_regdst, nj_iord, nj_alusrca, nj_irwrite, nj_memwrite;
  logic       nj_regwrite, nj_pcen, nj_illegal;
  logic [1:0] nj_pcsrc, nj_alusrcb;
  logic [2:0] nj_alucontrol;
  logic [3:0] nj_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal),
    .state(state)
  );

  mips_multicycle_controller #(.ENABLE_JUMP(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memtoreg(nj_memtoreg), .regdst(nj_regdst), .iord(nj_iord), .pcsrc(nj_pcsrc),
    .alusrca(nj_alusrca), .alusrcb(nj_alusrcb), .irwrite(nj_irwrite),
    .memwrite(nj_memwrite), .regwrite(nj_regwrite), .pcen(nj_pcen),
    .alucontrol(nj_alucontrol), .illegal(nj_illegal), .state(nj_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_s [5];
    logic [16:0] got;
    exp_s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    reset = 1'b1; op = 6'b100011; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {state, irwrite, pcen, alusrcb, iord, alusrca, pcsrc, regwrite, memwrite, alucontrol};
      checks++;
      if (got !== {4'd0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010}) begin
        failures++;
        $display("FAIL reset_fetch cycle %0d: got %h expected %h", i, got,
                 {4'd0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== exp_s[i] || regwrite !== (exp_s[i] == 4'd4) ||
          memtoreg !== (exp_s[i] == 4'd4) || pcen !== (exp_s[i] == 4'd0)) begin
        failures++;
        $display("FAIL lw_step %0d: state=%0d regwrite=%b memtoreg=%b pcen=%b expected state=%0d",
                 i, state, regwrite, memtoreg, pcen, exp_s[i]);
      end
    end
  endtask

  task automatic test_rtype();
    op = 6'b000000; funct = 6'b100010;
    tick();
    checks++;
    if (state !== 4'd1 || illegal !== 1'b0 || alusrcb !== 2'b11) begin
      failures++;
      $display("FAIL rtype_decode: state=%0d illegal=%b alusrcb=%b expected 1/0/11", state, illegal, alusrcb);
    end
    tick();
    checks++;
    if (state !== 4'd6 || alucontrol !== 3'b110 || illegal !== 1'b0 || alusrca !== 1'b1) begin
      failures++;
      $display("FAIL rtype_ex: state=%0d alucontrol=%b illegal=%b expected 6/110/0", state, alucontrol, illegal);
    end
    tick();
    checks++;
    if (state !== 4'd7 || regwrite !== 1'b1 || regdst !== 1'b1 || memtoreg !== 1'b0) begin
      failures++;
      $display("FAIL rtype_wb: state=%0d regwrite=%b regdst=%b expected 7/1/1", state, regwrite, regdst);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL rtype_return: state=%0d expected 0", state);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4];
    logic       zs [4];
    logic [3:0] exs [4];
    logic       pcs [4];
    ops = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exs = '{4'd8, 4'd8, 4'd9, 4'd9};
    pcs = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      op = ops[i]; zero = zs[i];
      tick();
      tick();
      checks++;
      if (state !== exs[i] || pcen !== pcs[i] || pcsrc !== 2'b01 || alucontrol !== 3'b110) begin
        failures++;
        $display("FAIL branch %0d: state=%0d pcen=%b pcsrc=%b alu=%b expected %0d/%b/01/110",
                 i, state, pcen, pcsrc, alucontrol, exs[i], pcs[i]);
      end
      tick();
      checks++;
      if (state !== 4'd0) begin
        failures++;
        $display("FAIL branch_return %0d: state=%0d expected 0", i, state);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [4];
    exp_s = '{4'd1, 4'd2, 4'd5, 4'd0};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== exp_s[i] || memwrite !== (exp_s[i] == 4'd5) || iord !== (exp_s[i] == 4'd5) ||
          regwrite !== 1'b0) begin
        failures++;
        $display("FAIL sw_step %0d: state=%0d memwrite=%b iord=%b expected state=%0d",
                 i, state, memwrite, iord, exp_s[i]);
      end
    end
  endtask

  task automatic test_addi();
    op = 6'b001000;
    tick();
    tick();
    checks++;
    if (state !== 4'd10 || alusrcb !== 2'b10 || alusrca !== 1'b1 || alucontrol !== 3'b010) begin
      failures++;
      $display("FAIL addi_ex: state=%0d alusrcb=%b alu=%b expected 10/10/010", state, alusrcb, alucontrol);
    end
    tick();
    checks++;
    if (state !== 4'd11 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin
      failures++;
      $display("FAIL addi_wb: state=%0d regwrite=%b regdst=%b expected 11/1/0", state, regwrite, regdst);
    end
    tick();
  endtask

  task automatic test_illegal_op();
    op = 6'b111111;
    tick();
    checks++;
    if (state !== 4'd1 || illegal !== 1'b1 || nj_illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_op_decode: state=%0d illegal=%b nj_illegal=%b expected 1/1/1", state, illegal, nj_illegal);
    end
    tick();
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || pcen !== 1'b1) begin
      failures++;
      $display("FAIL illegal_op_after: state=%0d illegal=%b expected 0/0", state, illegal);
    end
  endtask

  task automatic test_jump();
    op = 6'b000010;
    tick();
    checks++;
    if (illegal !== 1'b0 || nj_state !== 4'd1 || nj_illegal !== 1'b1) begin
      failures++;
      $display("FAIL jump_decode: illegal=%b nj_state=%0d nj_illegal=%b expected 0/1/1", illegal, nj_state, nj_illegal);
    end
    tick();
    checks++;
    if (state !== 4'd12 || pcsrc !== 2'b10 || pcen !== 1'b1 || nj_state !== 4'd0 || nj_illegal !== 1'b0) begin
      failures++;
      $display("FAIL jump_ex: state=%0d pcsrc=%b pcen=%b nj_state=%0d expected 12/10/1/0", state, pcsrc, pcen, nj_state);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL jump_return: state=%0d expected 0", state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_illegal_funct();
    op = 6'b000000; funct = 6'b111111;
    tick();
    tick();
    checks++;
    if (state !== 4'd6 || illegal !== 1'b1 || alucontrol !== 3'b010) begin
      failures++;
      $display("FAIL bad_funct_ex: state=%0d illegal=%b alu=%b expected 6/1/010", state, illegal, alucontrol);
    end
    tick();
    checks++;
    if (state !== 4'd7 || illegal !== 1'b0 || regwrite !== 1'b1) begin
      failures++;
      $display("FAIL bad_funct_wb: state=%0d illegal=%b regwrite=%b expected 7/0/1", state, illegal, regwrite);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 4'd0 || irwrite !== 1'b1 || regwrite !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: state=%0d irwrite=%b regwrite=%b expected 0/1/0", state, irwrite, regwrite);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_sw();
    test_addi();
    test_illegal_op();
    test_jump();
    test_illegal_funct();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Multicycle successor to the single-cycle MIPS Controller. It is a Moore FSM that sequences FETCH/DECODE/execute/memory/writeback over several clocks, with an embedded ALU decoder. It drives the multicycle datapath (shared instruction/data memory, IR, A/B/ALUOut registers). Optional instruction support (ADDI, J, BNE) is selected by parameter, and unsupported encodings are flagged.

Parameters:
ENABLE_ADDI, 1, decode opcode 001000 (addi); when 0, addi is treated as illegal
ENABLE_JUMP, 1, decode opcode 000010 (j); when 0, j is treated as illegal
ENABLE_BNE, 1, decode opcode 000101 (bne); when 0, bne is treated as illegal

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
memtoreg  out  1  1 selects data register for the register-file write data
regdst  out  1  1 selects rd, 0 selects rt
iord  out  1  1 selects ALUOut as memory address, 0 selects PC
pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
alusrca  out  1  0 selects PC, 1 selects A
alusrcb  out  2  00 B, 01 constant 4, 10 SignImm, 11 SignImm<<2
irwrite  out  1  IR load enable
memwrite  out  1  memory write strobe
regwrite  out  1  register-file write enable
pcen  out  1  PC load enable
alucontrol  out  3  ALU operation
illegal  out  1  one-cycle pulse for an unsupported op or funct
state  out  4  current state, for debug

Behaviour:
- Clock, reset: one clock, clk; reset is synchronous and active-high. Reset forces state=FETCH on the next rising edge, including mid-instruction.
- Outputs are Moore and decoded from state only. The exceptions are pcen, alucontrol, and illegal in DECODE/RTYPEEX.
- Outputs not listed for a state are 0. During and after reset, the outputs show FETCH values.
- States and outputs:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next state is DECODE.
  - DECODE(1): alusrca=0, alusrcb=11, aluop=00. Next state by op:
    - lw/sw → MEMADR
    - R(000000) → RTYPEEX
    - beq(000100) → BEQEX
    - bne → BNEEX
    - addi → ADDIEX
    - j → JEX
    - otherwise → FETCH with illegal=1
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00. lw(100011) → MEMRD; sw(101011) → MEMWR.
  - MEMRD(3): iord=1. Next state is MEMWB.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Next state is FETCH.
  - MEMWR(5): iord=1, memwrite=1. Next state is FETCH.
  - RTYPEEX(6): alusrca=1, alusrcb=00, aluop=10. Next state is RTYPEWB.
  - RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1. Next state is FETCH.
  - BEQEX(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next state is FETCH.
  - BNEEX(9): same outputs as BEQEX, plus an internal bne flag. Next state is FETCH.
  - ADDIEX(10): alusrca=1, alusrcb=10, aluop=00. Next state is ADDIWB.
  - ADDIWB(11): regdst=0, memtoreg=0, regwrite=1. Next state is FETCH.
  - JEX(12): pcsrc=10, pcwrite=1. Next state is FETCH.
  - Codes 13-15: unreachable; recover to FETCH.
- PC enable: pcen = pcwrite | (branch & (zero ^ bne)). It is combinational on zero.
- Latency in clocks, including FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq/bne 3
  - j 3
  - illegal 2
- ALU decoder, by aluop:
  - 00 → 010 (add)
  - 01 → 110 (sub)
  - 10 → by funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - any other funct → 010, and illegal=1 while in RTYPEEX; the writeback still occurs
  - 11 → 010
- A disabled optional opcode behaves exactly as an unknown opcode.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - ALU-control constants
  - state encoding localparams 0-12
  - aluop codes
- One sub-module: alu_decoder (aluop, funct → alucontrol, bad_funct), combinational, reused from the single-cycle design.

Test Plan:
- reset=1 for 2 cycles, then released with op=100011 → the FETCH outputs are present during reset. State sequence is 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4, and pcen=1 only in state 0.
- op=000000, funct=100010 → states 0,1,6,7,0. alucontrol=110 in state 6; regwrite=1 and regdst=1 in state 7.
- op=000100 with zero=1, then with zero=0 → pcen=1 in BEQEX for the first case, 0 for the second. For op=000101, pcen is the inverse. pcsrc=01 in both.
- op=101011 → states 0,1,2,5,0. memwrite=1 and iord=1 only in state 5.
- op=111111 → illegal=1 for exactly one cycle in DECODE, then FETCH. With ENABLE_JUMP=0, op=000010 gives the same result. With the default, j goes to JEX with pcsrc=10 and pcen=1.
- op=000000, funct=111111 → illegal pulse in RTYPEEX with alucontrol=010. Asserting reset in state 7 gives state=0 on the next edge.
